sky130_fd_io__refgen_ctrl_seq: RTL and testbench

//  Core-side sequencer that drives the control pins of the refgen I/O cell: ENABLE_H, ENABLE_VDDA_H, HLD_H_N and the select fields.

---
 rtl/sky130_fd_io__refgen_ctrl_pkg.sv | 43 ++++
 rtl/sky130_fd_io__refgen_ctrl_timer.sv | 34 +++
 rtl/sky130_fd_io__refgen_ctrl_seq.sv | 191 +++++++++++++++++++
 tb/tb_sky130_fd_io__refgen_ctrl_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sky130_fd_io__refgen_ctrl_pkg.sv
// Shared types and helpers for the refgen control sequencer.
//   refgen_state_e : sequencer states
//   refgen_cfg_t   : one complete set of refgen select bits
//   uses_vinref    : true when a config routes the reference through VINREF
//   cyc_to_load    : converts a state duration in cycles to a timer load value
//   max_int        : larger of two integers
package sky130_fd_io__refgen_ctrl_pkg;

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        EN_WAIT = 3'd1,
        APPLY   = 3'd2,
        SETTLE  = 3'd3,
        READY   = 3'd4,
        HOLD    = 3'd5
    } refgen_state_e;

    typedef struct packed {
        logic [2:0] voh_sel;
        logic [1:0] vref_sel;
        logic       ibuf_sel;
        logic       vtrip_sel;
        logic       vreg_en;
        logic       dft_refgen;
    } refgen_cfg_t;

    // VINREF is only in the path when the input buffer uses a selected
    // reference and the trip point is not the fixed VTRIP one.
    function automatic logic uses_vinref(input refgen_cfg_t cfg);
        return cfg.ibuf_sel && (cfg.vref_sel != 2'b00) && !cfg.vtrip_sel;
    endfunction

    // The timer is done when it reads 0, so a state of N cycles loads N-1.
    // Durations of 0 and 1 both collapse to a single-cycle state.
    function automatic int cyc_to_load(input int cyc);
        return (cyc <= 1) ? 0 : cyc - 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sky130_fd_io__refgen_ctrl_timer.sv
// Loadable down-counter used to time the sequencer states.
//   clk_i      : clock
//   rst_i      : asynchronous reset, active-high
//   load_i     : load load_val_i this cycle (state entry)
//   load_val_i : value to load
//   value_o    : current count
//   done_o     : count has reached 0
module sky130_fd_io__refgen_ctrl_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] value_o,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign value_o = cnt_q;
    assign done_o  = (cnt_q == '0);

endmodule

// File: rtl/sky130_fd_io__refgen_ctrl_seq.sv
// Core-side sequencer for the refgen I/O cell: powers the cell up, pushes
// configs through its HLD_H_N-transparent latches, waits for VOUTREF/VINREF
// to settle and manages hold-mode entry/exit.
//   CLK, RESET           : clock, asynchronous active-high reset
//   PWR_GOOD, EN_REQ     : rails good / core wants the refgen on
//   HOLD_REQ             : core wants the cell latches frozen
//   CFG_VALID/CFG_READY  : config handshake; a config transfers on a CLK
//                          rise where both are high. CFG_READY is
//                          combinational and does not depend on CFG_VALID.
//   CFG_*                : requested select bits
//   ENABLE_H, ENABLE_VDDA_H, HLD_H_N, VOH_SEL, VREF_SEL, IBUF_SEL,
//   VTRIP_SEL, VREG_EN, DFT_REFGEN : registered cell controls
//   REF_READY            : VOUTREF/VINREF are valid
module sky130_fd_io__refgen_ctrl_seq
    import sky130_fd_io__refgen_ctrl_pkg::*;
#(
    parameter int ENABLE_CYC         = 4,
    parameter int SETUP_CYC          = 2,
    parameter int STARTUP_CYC        = 50,
    parameter int STARTUP_VINREF_CYC = 50,
    parameter int CNT_W              = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PWR_GOOD,
    input  logic       EN_REQ,
    input  logic       HOLD_REQ,
    input  logic       CFG_VALID,
    output logic       CFG_READY,
    input  logic [2:0] CFG_VOH_SEL,
    input  logic [1:0] CFG_VREF_SEL,
    input  logic       CFG_IBUF_SEL,
    input  logic       CFG_VTRIP_SEL,
    input  logic       CFG_VREG_EN,
    input  logic       CFG_DFT_REFGEN,
    output logic       ENABLE_H,
    output logic       ENABLE_VDDA_H,
    output logic       HLD_H_N,
    output logic [2:0] VOH_SEL,
    output logic [1:0] VREF_SEL,
    output logic       IBUF_SEL,
    output logic       VTRIP_SEL,
    output logic       VREG_EN,
    output logic       DFT_REFGEN,
    output logic       REF_READY
);

    localparam int VINREF_SETTLE_CYC = max_int(STARTUP_CYC, STARTUP_VINREF_CYC);

    localparam logic [CNT_W-1:0] ENABLE_LD = CNT_W'(cyc_to_load(ENABLE_CYC));
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(cyc_to_load(SETUP_CYC));
    localparam logic [CNT_W-1:0] VOUT_LD   = CNT_W'(cyc_to_load(STARTUP_CYC));
    localparam logic [CNT_W-1:0] VIN_LD    = CNT_W'(cyc_to_load(VINREF_SETTLE_CYC));
    localparam logic [CNT_W-1:0] MAX_LD    = CNT_W'(cyc_to_load(
        max_int(max_int(ENABLE_CYC, SETUP_CYC), VINREF_SETTLE_CYC)));

    refgen_state_e    state_q, state_d;
    refgen_cfg_t      shadow_q, shadow_d;
    refgen_cfg_t      sel_q;
    refgen_cfg_t      cfg_in;
    logic             enable_h_q, enable_vdda_h_q, hld_h_n_q, ref_ready_q;
    logic             cfg_ready, cfg_acc;
    logic             tmr_load, tmr_done;
    logic [CNT_W-1:0] tmr_load_val, tmr_value;

    assign cfg_in = refgen_cfg_t'({CFG_VOH_SEL, CFG_VREF_SEL, CFG_IBUF_SEL,
                                   CFG_VTRIP_SEL, CFG_VREG_EN, CFG_DFT_REFGEN});

    // No handshakes while reset is held, and none while hold is requested so
    // a simultaneous config cannot sneak in ahead of the hold.
    assign cfg_ready = !RESET && ((state_q == OFF) || (state_q == READY)) && !HOLD_REQ;
    assign cfg_acc   = CFG_VALID && cfg_ready;
    assign shadow_d  = cfg_acc ? cfg_in : shadow_q;

    sky130_fd_io__refgen_ctrl_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .value_o    (tmr_value),
        .done_o     (tmr_done)
    );

    // Next state plus the timer load that goes with entering it.
    always_comb begin
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        if ((state_q != OFF) && (!PWR_GOOD || !EN_REQ)) begin
            state_d = OFF;
        end else begin
            unique case (state_q)
                OFF: if (EN_REQ && PWR_GOOD) begin
                    state_d      = EN_WAIT;
                    tmr_load     = 1'b1;
                    tmr_load_val = ENABLE_LD;
                end
                EN_WAIT: if (tmr_done) begin
                    state_d      = APPLY;
                    tmr_load     = 1'b1;
                    tmr_load_val = SETUP_LD;
                end
                APPLY: if (tmr_done) begin
                    // sel_q already holds the applied config at this point.
                    state_d      = SETTLE;
                    tmr_load     = 1'b1;
                    tmr_load_val = uses_vinref(sel_q) ? VIN_LD : VOUT_LD;
                end
                SETTLE: if (tmr_done) begin
                    state_d = READY;
                end
                READY: if (HOLD_REQ) begin
                    state_d = HOLD;
                end else if (cfg_acc) begin
                    state_d      = APPLY;
                    tmr_load     = 1'b1;
                    tmr_load_val = SETUP_LD;
                end
                HOLD: if (!HOLD_REQ) begin
                    state_d = READY;
                end
                default: state_d = OFF;
            endcase
        end
    end

    // Outputs only move on state entry. Selects load on APPLY entry, where
    // HLD_H_N is already high, so they never move with HLD_H_N or under hold.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q         <= OFF;
            shadow_q        <= '0;
            sel_q           <= '0;
            enable_h_q      <= 1'b0;
            enable_vdda_h_q <= 1'b0;
            hld_h_n_q       <= 1'b0;
            ref_ready_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            if (state_d != state_q) begin
                unique case (state_d)
                    OFF: begin
                        sel_q           <= '0;
                        enable_h_q      <= 1'b0;
                        enable_vdda_h_q <= 1'b0;
                        hld_h_n_q       <= 1'b0;
                        ref_ready_q     <= 1'b0;
                    end
                    EN_WAIT: begin
                        enable_h_q      <= 1'b1;
                        enable_vdda_h_q <= 1'b1;
                        hld_h_n_q       <= 1'b1;
                    end
                    APPLY: begin
                        sel_q       <= shadow_d;
                        hld_h_n_q   <= 1'b1;
                        ref_ready_q <= 1'b0;
                    end
                    READY: begin
                        hld_h_n_q   <= 1'b1;
                        ref_ready_q <= 1'b1;
                    end
                    HOLD: begin
                        hld_h_n_q <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // The timer is only ever loaded with one of the state durations.
    assert property (@(posedge CLK) disable iff (RESET) tmr_value <= MAX_LD);

    assign CFG_READY     = cfg_ready;
    assign ENABLE_H      = enable_h_q;
    assign ENABLE_VDDA_H = enable_vdda_h_q;
    assign HLD_H_N       = hld_h_n_q;
    assign VOH_SEL       = sel_q.voh_sel;
    assign VREF_SEL      = sel_q.vref_sel;
    assign IBUF_SEL      = sel_q.ibuf_sel;
    assign VTRIP_SEL     = sel_q.vtrip_sel;
    assign VREG_EN       = sel_q.vreg_en;
    assign DFT_REFGEN    = sel_q.dft_refgen;
    assign REF_READY     = ref_ready_q;

endmodule

// File: tb/tb_sky130_fd_io__refgen_ctrl_seq.sv
// Bench for the refgen control sequencer. Two instances share stimulus:
// dut_a uses the default timing, dut_b uses STARTUP_CYC=0 and
// STARTUP_VINREF_CYC=100. A phase/remaining-cycles model predicts every
// registered output after each clock and CFG_READY before each clock.
module tb_sky130_fd_io__refgen_ctrl_seq;

    localparam int P_OFF = 0, P_EN_WAIT = 1, P_APPLY = 2, P_SETTLE = 3, P_READY = 4, P_HOLD = 5;
    localparam int EN_CYC = 4, SU_CYC = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       pwr_good = 1'b0, en_req = 1'b0, hold_req = 1'b0, cfg_valid = 1'b0;
    logic [8:0] cfg_word = '0;   // {voh[2:0], vref[1:0], ibuf, vtrip, vreg, dft}

    logic       a_cfg_ready, a_en_h, a_en_vdda, a_hld, a_ibuf, a_vtrip, a_vreg, a_dft, a_ref_ready;
    logic [2:0] a_voh;
    logic [1:0] a_vref;
    logic       b_cfg_ready, b_en_h, b_en_vdda, b_hld, b_ibuf, b_vtrip, b_vreg, b_dft, b_ref_ready;
    logic [2:0] b_voh;
    logic [1:0] b_vref;
    logic [12:0] a_out, b_out;
    assign a_out = {a_en_h, a_en_vdda, a_hld, a_voh, a_vref, a_ibuf, a_vtrip, a_vreg, a_dft, a_ref_ready};
    assign b_out = {b_en_h, b_en_vdda, b_hld, b_voh, b_vref, b_ibuf, b_vtrip, b_vreg, b_dft, b_ref_ready};

    sky130_fd_io__refgen_ctrl_seq dut_a (
        .CLK(clk), .RESET(rst), .PWR_GOOD(pwr_good), .EN_REQ(en_req), .HOLD_REQ(hold_req),
        .CFG_VALID(cfg_valid), .CFG_READY(a_cfg_ready),
        .CFG_VOH_SEL(cfg_word[8:6]), .CFG_VREF_SEL(cfg_word[5:4]), .CFG_IBUF_SEL(cfg_word[3]),
        .CFG_VTRIP_SEL(cfg_word[2]), .CFG_VREG_EN(cfg_word[1]), .CFG_DFT_REFGEN(cfg_word[0]),
        .ENABLE_H(a_en_h), .ENABLE_VDDA_H(a_en_vdda), .HLD_H_N(a_hld),
        .VOH_SEL(a_voh), .VREF_SEL(a_vref), .IBUF_SEL(a_ibuf), .VTRIP_SEL(a_vtrip),
        .VREG_EN(a_vreg), .DFT_REFGEN(a_dft), .REF_READY(a_ref_ready)
    );

    sky130_fd_io__refgen_ctrl_seq #(.STARTUP_CYC(0), .STARTUP_VINREF_CYC(100)) dut_b (
        .CLK(clk), .RESET(rst), .PWR_GOOD(pwr_good), .EN_REQ(en_req), .HOLD_REQ(hold_req),
        .CFG_VALID(cfg_valid), .CFG_READY(b_cfg_ready),
        .CFG_VOH_SEL(cfg_word[8:6]), .CFG_VREF_SEL(cfg_word[5:4]), .CFG_IBUF_SEL(cfg_word[3]),
        .CFG_VTRIP_SEL(cfg_word[2]), .CFG_VREG_EN(cfg_word[1]), .CFG_DFT_REFGEN(cfg_word[0]),
        .ENABLE_H(b_en_h), .ENABLE_VDDA_H(b_en_vdda), .HLD_H_N(b_hld),
        .VOH_SEL(b_voh), .VREF_SEL(b_vref), .IBUF_SEL(b_ibuf), .VTRIP_SEL(b_vtrip),
        .VREG_EN(b_vreg), .DFT_REFGEN(b_dft), .REF_READY(b_ref_ready)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int         phase;
        int         left;     // cycles still to spend in a timed phase
        logic [8:0] shadow;
        logic [8:0] sel;
        logic       en;
        logic       hld;
        logic       rr;
    } mdl_t;

    mdl_t ma, mb;
    int   cyc = 0;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.phase = P_OFF; m.left = 0; m.shadow = '0; m.sel = '0;
        m.en = 1'b0; m.hld = 1'b0; m.rr = 1'b0;
        return m;
    endfunction

    function automatic int dur(input int n);
        return (n < 1) ? 1 : n;
    endfunction

    function automatic logic mdl_cfg_ready(input mdl_t m);
        return !rst && !hold_req && (m.phase == P_OFF || m.phase == P_READY);
    endfunction

    function automatic logic [12:0] mdl_out(input mdl_t m);
        return {m.en, m.en, m.hld, m.sel, m.rr};
    endfunction

    // One clock of the sequencer, from the current inputs.
    function automatic mdl_t mdl_step(input mdl_t m, input int startup, input int startup_vin);
        mdl_t n;
        logic acc, vin;
        n   = m;
        acc = cfg_valid && mdl_cfg_ready(m);
        if (acc) n.shadow = cfg_word;
        if (m.phase != P_OFF && !(pwr_good && en_req)) begin
            n.phase = P_OFF; n.left = 0; n.sel = '0; n.en = 1'b0; n.hld = 1'b0; n.rr = 1'b0;
            return n;
        end
        case (m.phase)
            P_OFF: if (en_req && pwr_good) begin
                n.phase = P_EN_WAIT; n.left = dur(EN_CYC); n.en = 1'b1; n.hld = 1'b1;
            end
            P_EN_WAIT: if (m.left == 1) begin
                n.phase = P_APPLY; n.left = dur(SU_CYC); n.sel = n.shadow;
            end else n.left = m.left - 1;
            P_APPLY: if (m.left == 1) begin
                vin     = m.sel[3] && (m.sel[5:4] != 2'b00) && !m.sel[2];
                n.phase = P_SETTLE;
                n.left  = dur(vin ? ((startup > startup_vin) ? startup : startup_vin) : startup);
            end else n.left = m.left - 1;
            P_SETTLE: if (m.left == 1) begin
                n.phase = P_READY; n.rr = 1'b1;
            end else n.left = m.left - 1;
            P_READY: if (hold_req) begin
                n.phase = P_HOLD; n.hld = 1'b0;
            end else if (acc) begin
                n.phase = P_APPLY; n.left = dur(SU_CYC); n.sel = n.shadow; n.rr = 1'b0;
            end
            P_HOLD: if (!hold_req) begin
                n.phase = P_READY; n.hld = 1'b1;
            end
            default: n.phase = P_OFF;
        endcase
        return n;
    endfunction

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    endtask

    // ---------------- drivers ----------------
    // Inputs are changed by callers just after a rising edge; this checks
    // CFG_READY mid-cycle, clocks once and checks the registered outputs.
    task automatic cycle_step();
        @(negedge clk);
        #1;
        check("cfg_ready_a", 32'(a_cfg_ready), 32'(mdl_cfg_ready(ma)));
        check("cfg_ready_b", 32'(b_cfg_ready), 32'(mdl_cfg_ready(mb)));
        @(posedge clk);
        if (rst) begin
            ma = mdl_reset();
            mb = mdl_reset();
        end else begin
            ma = mdl_step(ma, 50, 50);
            mb = mdl_step(mb, 0, 100);
        end
        #1;
        cyc++;
        check("outputs_a", 32'(a_out), 32'(mdl_out(ma)));
        check("outputs_b", 32'(b_out), 32'(mdl_out(mb)));
    endtask

    // Clocks until both REF_READY are seen high; returns the cycle index of
    // each first rise, counting the first clock of the call as 1. CFG_VALID
    // is only offered on that first clock.
    task automatic measure_ready(input int bound, output int ra, output int rb);
        ra = 0;
        rb = 0;
        for (int k = 1; k <= bound && (ra == 0 || rb == 0); k++) begin
            cycle_step();
            if (k == 1) cfg_valid = 1'b0;
            if (ra == 0 && a_ref_ready) ra = k;
            if (rb == 0 && b_ref_ready) rb = k;
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_a", 32'(a_out), 32'h0);
        check("async_rst_b", 32'(b_out), 32'h0);
        ma = mdl_reset();
        mb = mdl_reset();
        cycle_step();
        cycle_step();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ra, rb, low_a, low_b, first_low;
        ma = mdl_reset();
        mb = mdl_reset();

        // Reset state
        cycle_step();
        cycle_step();
        rst = 1'b0;
        cycle_step();

        // Power-up with an all-zero shadow
        en_req   = 1'b1;
        pwr_good = 1'b1;
        cycle_step();
        check("enable_h_cycle1", 32'(a_en_h), 32'd1);
        measure_ready(200, ra, rb);
        check("bringup_ready_a", 32'(ra + 1), 32'd57);
        check("bringup_ready_b", 32'(rb + 1), 32'd8);

        // Reconfigure to a VINREF-using config
        cfg_word  = 9'b101_10_1_0_0_0;
        cfg_valid = 1'b1;
        measure_ready(200, ra, rb);
        check("vinref_ready_a", 32'(ra), 32'd53);
        check("vinref_ready_b", 32'(rb), 32'd103);
        check("vinref_sel_a", 32'({a_voh, a_vref, a_ibuf, a_vtrip}), 32'({3'b101, 2'b10, 1'b1, 1'b0}));

        // VTRIP selected: VINREF no longer in use
        cfg_word  = 9'b101_10_1_1_0_0;
        cfg_valid = 1'b1;
        measure_ready(200, ra, rb);
        check("vtrip_ready_a", 32'(ra), 32'd53);
        check("vtrip_ready_b", 32'(rb), 32'd4);

        // Hold for 10 cycles with a config offered at the same time
        hold_req  = 1'b1;
        cfg_valid = 1'b1;
        cfg_word  = 9'(($urandom_range(0, 511)));
        low_a = 0;
        low_b = 0;
        for (int k = 0; k < 10; k++) begin
            cycle_step();
            if (!a_hld) low_a++;
            if (!b_hld) low_b++;
        end
        check("hold_cycles_a", 32'(low_a), 32'd10);
        check("hold_cycles_b", 32'(low_b), 32'd10);
        hold_req  = 1'b0;
        cfg_valid = 1'b0;
        cycle_step();
        check("hold_release_a", 32'(a_hld), 32'd1);
        check("hold_sel_kept_a", 32'({a_voh, a_vref, a_ibuf, a_vtrip}), 32'({3'b101, 2'b10, 1'b1, 1'b1}));

        // Hold requested while settling is deferred until READY
        cfg_word  = 9'b000_00_0_0_0_0;
        cfg_valid = 1'b1;
        cycle_step();
        cfg_valid = 1'b0;
        hold_req  = 1'b1;
        first_low = 0;
        for (int k = 2; k <= 100 && first_low == 0; k++) begin
            cycle_step();
            if (!a_hld) first_low = k;
        end
        check("deferred_hold_a", 32'(first_low), 32'd54);
        hold_req = 1'b0;
        cycle_step();

        // Power drop mid-settle, then restart from the retained shadow
        cfg_word  = 9'b000_01_1_0_0_0;
        cfg_valid = 1'b1;
        cycle_step();
        cfg_valid = 1'b0;
        repeat (4) cycle_step();
        pwr_good = 1'b0;
        cycle_step();
        check("pg_drop_a", 32'(a_out), 32'h0);
        check("pg_drop_b", 32'(b_out), 32'h0);
        pwr_good = 1'b1;
        measure_ready(200, ra, rb);
        check("restart_ready_a", 32'(ra), 32'd57);
        check("restart_ready_b", 32'(rb), 32'd107);

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 999) == 0) async_reset();
            pwr_good  = pwr_good ? ($urandom_range(0, 299) != 0) : ($urandom_range(0, 4) == 0);
            en_req    = en_req ? ($urandom_range(0, 299) != 0) : ($urandom_range(0, 4) == 0);
            hold_req  = hold_req ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 29) == 0);
            cfg_valid = ($urandom_range(0, 9) == 0);
            cfg_word  = 9'($urandom_range(0, 511));
            cycle_step();
        end
        async_reset();
        cycle_step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
